// File: rtl/vga_scan_gen.sv
// Raster scan generator: pixel-rate divider, horizontal/vertical counters and
// the sync, blanking, coordinate and line/frame pulse decodes derived from them.
module vga_scan_gen #(
   parameter int CLK_DIV  = 2,
   parameter int H_ACTIVE = 640,
   parameter int H_FP     = 16,
   parameter int H_SYNC   = 96,
   parameter int H_BP     = 48,
   parameter int V_ACTIVE = 480,
   parameter int V_FP     = 10,
   parameter int V_SYNC   = 2,
   parameter int V_BP     = 33
) (
   input  logic        clk,
   input  logic        reset,
   output logic        pix_en,
   output logic [9:0]  curr_x,
   output logic [8:0]  curr_y,
   output logic        hsync,
   output logic        vsync,
   output logic        video_on,
   output logic        line_start,
   output logic        frame_start,
   output logic [15:0] frame_count
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   localparam logic [DIV_W-1:0] DIV_MAX   = DIV_W'(CLK_DIV - 1);
   localparam logic [9:0]       H_MAX     = 10'(H_TOTAL - 1);
   localparam logic [9:0]       V_MAX     = 10'(V_TOTAL - 1);
   localparam logic [9:0]       H_ACT     = 10'(H_ACTIVE);
   localparam logic [9:0]       V_ACT     = 10'(V_ACTIVE);
   localparam logic [9:0]       HS_START  = 10'(H_ACTIVE + H_FP);
   localparam logic [9:0]       HS_END    = 10'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [9:0]       VS_START  = 10'(V_ACTIVE + V_FP);
   localparam logic [9:0]       VS_END    = 10'(V_ACTIVE + V_FP + V_SYNC);

   logic [DIV_W-1:0] r_div_cnt;
   logic [9:0]       r_h_cnt;
   logic [9:0]       r_v_cnt;
   logic [15:0]      r_frame_count;

   logic w_pix_en;
   logic w_h_wrap;
   logic w_v_wrap;
   logic w_video_on;
   logic w_h_zero;

   assign w_pix_en = (r_div_cnt == DIV_MAX);
   assign w_h_wrap = (r_h_cnt == H_MAX);
   assign w_v_wrap = (r_v_cnt == V_MAX);

   // Counters step only on pixel strobes; reset wins over a coincident strobe.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_div_cnt     <= '0;
         r_h_cnt       <= '0;
         r_v_cnt       <= '0;
         r_frame_count <= '0;
      end else if (w_pix_en) begin
         r_div_cnt <= '0;
         if (w_h_wrap) begin
            r_h_cnt <= '0;
            if (w_v_wrap) begin
               r_v_cnt       <= '0;
               r_frame_count <= r_frame_count + 16'd1;
            end else begin
               r_v_cnt <= r_v_cnt + 10'd1;
            end
         end else begin
            r_h_cnt <= r_h_cnt + 10'd1;
         end
      end else begin
         r_div_cnt <= r_div_cnt + 1'b1;
      end
   end

   assign w_video_on = (r_h_cnt < H_ACT) && (r_v_cnt < V_ACT);
   assign w_h_zero   = (r_h_cnt == 10'd0);

   assign pix_en      = w_pix_en;
   assign video_on    = w_video_on;
   assign curr_x      = w_video_on ? r_h_cnt : 10'd0;
   assign curr_y      = w_video_on ? r_v_cnt[8:0] : 9'd0;
   assign hsync       = !((r_h_cnt >= HS_START) && (r_h_cnt < HS_END));
   assign vsync       = !((r_v_cnt >= VS_START) && (r_v_cnt < VS_END));
   assign line_start  = w_pix_en && w_h_zero;
   assign frame_start = w_pix_en && w_h_zero && (r_v_cnt == 10'd0);
   assign frame_count = r_frame_count;

endmodule

// File: tb/tb_vga_scan_gen.sv
// Bench for vga_scan_gen: one default-timing instance plus two reduced-timing
// instances (CLK_DIV 1 and 3) run in lockstep against a cycle-index model.
module tb_vga_scan_gen;

   typedef struct packed {
      logic        pe;
      logic [9:0]  x;
      logic [8:0]  y;
      logic        hs;
      logic        vs;
      logic        von;
      logic        ls;
      logic        fs;
      logic [15:0] fc;
   } obs_t;

   typedef struct {
      logic rst;
      obs_t exp;
   } vec_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_d = 1'b1, rst_s1 = 1'b1, rst_s3 = 1'b1;

   logic pe_d, hs_d, vs_d, von_d, ls_d, fs_d;
   logic [9:0] x_d; logic [8:0] y_d; logic [15:0] fc_d;
   logic pe_s1, hs_s1, vs_s1, von_s1, ls_s1, fs_s1;
   logic [9:0] x_s1; logic [8:0] y_s1; logic [15:0] fc_s1;
   logic pe_s3, hs_s3, vs_s3, von_s3, ls_s3, fs_s3;
   logic [9:0] x_s3; logic [8:0] y_s3; logic [15:0] fc_s3;

   vga_scan_gen dut_d (
      .clk(clk), .reset(rst_d), .pix_en(pe_d), .curr_x(x_d), .curr_y(y_d),
      .hsync(hs_d), .vsync(vs_d), .video_on(von_d), .line_start(ls_d),
      .frame_start(fs_d), .frame_count(fc_d));

   vga_scan_gen #(.CLK_DIV(1), .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
                  .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(1)) dut_s1 (
      .clk(clk), .reset(rst_s1), .pix_en(pe_s1), .curr_x(x_s1), .curr_y(y_s1),
      .hsync(hs_s1), .vsync(vs_s1), .video_on(von_s1), .line_start(ls_s1),
      .frame_start(fs_s1), .frame_count(fc_s1));

   vga_scan_gen #(.CLK_DIV(3), .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
                  .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(1)) dut_s3 (
      .clk(clk), .reset(rst_s3), .pix_en(pe_s3), .curr_x(x_s3), .curr_y(y_s3),
      .hsync(hs_s3), .vsync(vs_s3), .video_on(von_s3), .line_start(ls_s3),
      .frame_start(fs_s3), .frame_count(fc_s3));

   obs_t obs_d, obs_s1, obs_s3;
   assign obs_d  = {pe_d, x_d, y_d, hs_d, vs_d, von_d, ls_d, fs_d, fc_d};
   assign obs_s1 = {pe_s1, x_s1, y_s1, hs_s1, vs_s1, von_s1, ls_s1, fs_s1, fc_s1};
   assign obs_s3 = {pe_s3, x_s3, y_s3, hs_s3, vs_s3, von_s3, ls_s3, fs_s3, fc_s3};

   int n_cmp = 0;
   int n_bad = 0;
   // Clocks elapsed since each instance's last reset edge, plus frame-count offset.
   int n_d = 0, n_s1 = 0, n_s3 = 0;
   int base_s1 = 0;

   // Pixel n of a raster is pixel n/cd; position and pulses follow by division.
   function automatic obs_t model(int cd, int ha, int hf, int hsw, int hb,
                                  int va, int vf, int vsw, int vb, int n, int base);
      obs_t o;
      int ht, vt, p, h, v;
      ht = ha + hf + hsw + hb;
      vt = va + vf + vsw + vb;
      p  = n / cd;
      h  = p % ht;
      v  = (p / ht) % vt;
      o.pe  = ((n % cd) == cd - 1);
      o.von = (h < ha) && (v < va);
      o.x   = o.von ? 10'(h) : 10'd0;
      o.y   = o.von ? 9'(v) : 9'd0;
      o.hs  = !((h >= ha + hf) && (h < ha + hf + hsw));
      o.vs  = !((v >= va + vf) && (v < va + vf + vsw));
      o.ls  = o.pe && (h == 0);
      o.fs  = o.ls && (v == 0);
      o.fc  = 16'(base + p / (ht * vt));
      return o;
   endfunction

   function automatic obs_t mk(logic pe, int x, int y, logic hs, logic vs,
                               logic von, logic ls, logic fs, int fc);
      obs_t o;
      o = {pe, 10'(x), 9'(y), hs, vs, von, ls, fs, 16'(fc)};
      return o;
   endfunction

   task automatic chk(input string nm, input obs_t act, input obs_t exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got pe=%b x=%0d y=%0d hs=%b vs=%b von=%b ls=%b fs=%b fc=%0d want pe=%b x=%0d y=%0d hs=%b vs=%b von=%b ls=%b fs=%b fc=%0d",
                  nm, act.pe, act.x, act.y, act.hs, act.vs, act.von, act.ls, act.fs, act.fc,
                  exp.pe, exp.x, exp.y, exp.hs, exp.vs, exp.von, exp.ls, exp.fs, exp.fc);
      end
   endtask

   task automatic chk_int(input string nm, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d want %0d", nm, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      n_d  = rst_d  ? 0 : n_d + 1;
      n_s3 = rst_s3 ? 0 : n_s3 + 1;
      if (rst_s1) begin
         n_s1    = 0;
         base_s1 = 0;
      end else begin
         n_s1 = n_s1 + 1;
      end
      #1;
      chk("d_cycle",  obs_d,  model(2, 640, 16, 96, 48, 480, 10, 2, 33, n_d, 0));
      chk("s1_cycle", obs_s1, model(1, 8, 2, 3, 2, 6, 1, 2, 1, n_s1, base_s1));
      chk("s3_cycle", obs_s3, model(3, 8, 2, 3, 2, 6, 1, 2, 1, n_s3, 0));
   endtask

   vec_t tbl[7];

   initial begin
      int last_ls_d, hs_fall_d, prev_hs_d, prev_von_d, prev_x_d;
      int last_fs_s1, last_fs_s3, vs_fall_s1, vs_fall_s3, prev_vs_s1, prev_vs_s3;
      int pe_low_s1;
      bit found;

      tbl[0] = '{1'b1, mk(0, 0, 0, 1, 1, 1, 0, 0, 0)};
      tbl[1] = '{1'b1, mk(0, 0, 0, 1, 1, 1, 0, 0, 0)};
      tbl[2] = '{1'b1, mk(0, 0, 0, 1, 1, 1, 0, 0, 0)};
      tbl[3] = '{1'b0, mk(1, 0, 0, 1, 1, 1, 1, 1, 0)};
      tbl[4] = '{1'b0, mk(0, 1, 0, 1, 1, 1, 0, 0, 0)};
      tbl[5] = '{1'b0, mk(1, 1, 0, 1, 1, 1, 0, 0, 0)};
      tbl[6] = '{1'b0, mk(0, 2, 0, 1, 1, 1, 0, 0, 0)};

      // Reset hold and release on all instances, table-checked on the default one.
      for (int i = 0; i < 7; i++) begin
         rst_d  = tbl[i].rst;
         rst_s1 = tbl[i].rst;
         rst_s3 = tbl[i].rst;
         step();
         chk($sformatf("reset_vec%0d", i), obs_d, tbl[i].exp);
      end

      // Free run: two default lines, many reduced frames.
      last_ls_d = -1; hs_fall_d = -1; prev_hs_d = 1; prev_von_d = 1; prev_x_d = 0;
      last_fs_s1 = -1; last_fs_s3 = -1; vs_fall_s1 = -1; vs_fall_s3 = -1;
      prev_vs_s1 = 1; prev_vs_s3 = 1; pe_low_s1 = 0;
      for (int i = 0; i < 3400; i++) begin
         step();
         if (ls_d) begin
            if (last_ls_d >= 0) chk_int("d_line_period", n_d - last_ls_d, 1600);
            last_ls_d = n_d;
         end
         if (prev_hs_d == 1 && hs_d == 0) begin
            hs_fall_d = n_d;
            if (last_ls_d >= 0) chk_int("d_hsync_offset", n_d - last_ls_d, 1311);
         end
         if (prev_hs_d == 0 && hs_d == 1 && hs_fall_d >= 0)
            chk_int("d_hsync_width", n_d - hs_fall_d, 192);
         if (prev_von_d == 1 && von_d == 0) begin
            chk_int("d_von_fall_prev_x", prev_x_d, 639);
            chk_int("d_von_fall_x", int'(x_d), 0);
         end
         prev_hs_d = hs_d; prev_von_d = von_d; prev_x_d = int'(x_d);

         if (!pe_s1) pe_low_s1++;
         if (fs_s1) begin
            if (last_fs_s1 >= 0) chk_int("s1_frame_period", n_s1 - last_fs_s1, 150);
            if (n_s1 == 150) chk_int("s1_first_frame_count", int'(fc_s1), 1);
            last_fs_s1 = n_s1;
         end
         if (fs_s3) begin
            if (last_fs_s3 >= 0) chk_int("s3_frame_period", n_s3 - last_fs_s3, 450);
            if (n_s3 == 452) chk_int("s3_second_fs_count", int'(fc_s3), 1);
            last_fs_s3 = n_s3;
         end
         if (prev_vs_s1 == 1 && vs_s1 == 0) vs_fall_s1 = n_s1;
         if (prev_vs_s1 == 0 && vs_s1 == 1 && vs_fall_s1 >= 0)
            chk_int("s1_vsync_width", n_s1 - vs_fall_s1, 30);
         if (prev_vs_s3 == 1 && vs_s3 == 0) vs_fall_s3 = n_s3;
         if (prev_vs_s3 == 0 && vs_s3 == 1 && vs_fall_s3 >= 0)
            chk_int("s3_vsync_width", n_s3 - vs_fall_s3, 90);
         prev_vs_s1 = vs_s1; prev_vs_s3 = vs_s3;
         if (von_s3 && y_s3 >= 9'd6) chk_int("s3_y_in_active", int'(y_s3), 5);
      end
      chk_int("s1_pix_en_low_cycles", pe_low_s1, 0);

      // Mid-frame reset on the CLK_DIV=3 raster while both syncs are low.
      found = 0;
      for (int i = 0; i < 600 && !found; i++) begin
         if ((n_s3 / 3) % 15 == 11 && (n_s3 / 45) % 10 == 8) found = 1;
         else step();
      end
      chk_int("midreset_reached", int'(found), 1);
      chk_int("midreset_pre_hs", int'(hs_s3), 0);
      chk_int("midreset_pre_vs", int'(vs_s3), 0);
      rst_s3 = 1'b1;
      step();
      rst_s3 = 1'b0;
      chk("midreset_state", obs_s3, mk(0, 0, 0, 1, 1, 1, 0, 0, 0));
      step();
      chk_int("midreset_no_fs_yet", int'(fs_s3), 0);
      step();
      chk("midreset_first_fs", obs_s3, mk(1, 0, 0, 1, 1, 1, 1, 1, 0));

      // Frame counter wrap on the CLK_DIV=1 raster.
      rst_s1 = 1'b1;
      step();
      rst_s1 = 1'b0;
      force dut_s1.r_frame_count = 16'hFFFF;
      base_s1 = 65535;
      #1;
      release dut_s1.r_frame_count;
      step();
      chk_int("wrap_preset", int'(fc_s1), 65535);
      found = 0;
      for (int i = 0; i < 300 && !found; i++) begin
         step();
         if (fs_s1) begin
            found = 1;
            chk_int("wrap_count_zero", int'(fc_s1), 0);
            chk_int("wrap_edge_index", n_s1, 150);
         end
      end
      chk_int("wrap_reached", int'(found), 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/vga_scan_gen.md
# vga_scan_gen

Raster scan generator for the 640x480 @ 60 Hz VGA display path. It divides the system clock into a pixel enable and runs the horizontal and vertical counters. From those counters it drives the sync pulses, the active-video flag and the current pixel coordinates (`curr_x`, `curr_y`). Note, fret and UI hit-test logic compares these coordinates against object rectangles, and the frame/line pulses pace note scrolling and game logic.

## Interface
- `CLK_DIV`, default 2: system clocks per pixel; legal values ≥1.
- `H_ACTIVE`, default 640: active pixels per line.
- `H_FP`, default 16: horizontal front porch, in pixels.
- `H_SYNC`, default 96: hsync width, in pixels.
- `H_BP`, default 48: horizontal back porch, in pixels.
- `V_ACTIVE`, default 480: active lines per frame.
- `V_FP`, default 10: vertical front porch, in lines.
- `V_SYNC`, default 2: vsync width, in lines.
- `V_BP`, default 33: vertical back porch, in lines.

Ports:
- `clk`  in  1  system clock; single clock domain.
- `reset`  in  1  synchronous, active-high reset.
- `pix_en`  out  1  pixel strobe; high one `clk` in every `CLK_DIV`.
- `curr_x`  out  10  column; `h_cnt` when active, else 0.
- `curr_y`  out  9  row; `v_cnt` when active line, else 0.
- `hsync`  out  1  active-low horizontal sync.
- `vsync`  out  1  active-low vertical sync.
- `video_on`  out  1  high when `h_cnt<H_ACTIVE` and `v_cnt<V_ACTIVE`.
- `line_start`  out  1  one-`clk` pulse at the start of each line.
- `frame_start`  out  1  one-`clk` pulse at the start of each frame.
- `frame_count`  out  16  frames completed since reset; wraps modulo 2^16.

## Operation
- Derived constants:
  - H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP = 800.
  - V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP = 525.
- Registers:
  - `div_cnt`: `$clog2(CLK_DIV)` bits, minimum 1.
  - `h_cnt`: 10 bits.
  - `v_cnt`: 10 bits.
  - `frame_count`: 16 bits.
- Divider:
  - `pix_en = (div_cnt == CLK_DIV-1)`, decoded combinationally.
  - `div_cnt` increments every `clk` and wraps to 0 when `pix_en` is high.
  - With `CLK_DIV=1`, `pix_en` is constantly 1.
- Counters advance only on `clk` edges where `pix_en=1`:
  - `h_cnt`: if `h_cnt == H_TOTAL-1` then 0, else `h_cnt+1`.
  - On an `h_cnt` wrap, `v_cnt` becomes 0 if `v_cnt == V_TOTAL-1`, else `v_cnt+1`.
  - On an `h_cnt` wrap with `v_cnt == V_TOTAL-1`, `frame_count` increments (wrapping at 2^16).
- Decodes, all combinational from the registered counters:
  - `hsync = 0` when `H_ACTIVE+H_FP ≤ h_cnt < H_ACTIVE+H_FP+H_SYNC`, i.e. 656..751.
  - `vsync = 0` when `V_ACTIVE+V_FP ≤ v_cnt < V_ACTIVE+V_FP+V_SYNC`, i.e. 490..491.
  - `video_on` as defined in the port list.
  - `curr_x = video_on ? h_cnt : 0`.
  - `curr_y = video_on ? v_cnt[8:0] : 0`.
  - `line_start = pix_en & (h_cnt==0)`.
  - `frame_start = pix_en & (h_cnt==0) & (v_cnt==0)`.
- Every pulse output is qualified by `pix_en`, so each pulse is exactly one `clk` wide.
- Hit-test consumers use strict comparisons against `curr_x`/`curr_y`. The zeros driven during blanking must therefore be masked with `video_on` by the consumer.

## Timing
- Reset, synchronous:
  - `div_cnt`, `h_cnt`, `v_cnt` and `frame_count` clear to 0.
  - Resulting outputs: `pix_en = (CLK_DIV==1)`, `curr_x=0`, `curr_y=0`, `hsync=1`, `vsync=1`, `video_on=1`, `line_start = frame_start = pix_en`, `frame_count=0`.
- Reset asserted mid-frame has the same effect: the new frame starts at 0,0 with no partial sync pulses carried over. Reset dominates `pix_en`.
- First `frame_start` after reset is released: cycle `CLK_DIV-1`, counting the first post-reset edge as cycle 0.
- Pulse periods:
  - `frame_start`: every H_TOTAL·V_TOTAL·CLK_DIV = 840000 `clk` (defaults).
  - `line_start`: every 1600 `clk`.
- Each pixel coordinate is held for exactly `CLK_DIV` `clk` cycles.
- Outputs are combinational from registers, so latency from a counter edge to the output is 0 cycles. Consumers register them if they need to.
- Boundaries:
  - `h_cnt` 799→0 and `v_cnt` 524→0 on the same edge: `frame_count` increments on that edge.
  - `v_cnt` never exceeds 524.
  - `curr_y` never exceeds 479.

## Test plan
- Reset:
  - Stimulus: hold `reset` for 3 cycles, then release.
  - Required: outputs hold the reset values above; `pix_en` is first high on the 2nd post-reset cycle; `frame_start=1` on that cycle with `curr_x=0`, `curr_y=0`.
- Horizontal timing:
  - Stimulus: run one line.
  - Required: `hsync` is low for exactly 96·2 = 192 `clk`, starting when `curr_x` would be 656.
  - Required: `video_on` falls at `h_cnt=640`, when `curr_x` drops 639→0.
  - Required: `line_start` period is 1600 `clk`.
- Vertical timing:
  - Stimulus: run one full frame.
  - Required: `vsync` is low for 2 lines (3200 `clk`) at `v_cnt` 490..491; `video_on` is never high while `v_cnt ≥ 480`.
  - Required: next `frame_start` arrives 840000 `clk` later and `frame_count` reads 1.
- Mid-frame reset:
  - Stimulus: assert `reset` for 1 cycle at `h_cnt=700`, `v_cnt=491`, while hsync and vsync are both low.
  - Required: next cycle `hsync=1`, `vsync=1`, counters are 0; `frame_start` fires at `pix_en`.
- Divider:
  - Stimulus: rerun the horizontal and vertical checks with `CLK_DIV=1`.
  - Required: `pix_en` is constantly high; frame period is 420000 `clk`.
- Wrap:
  - Stimulus: force `frame_count=16'hFFFF`, then complete a frame.
  - Required: `frame_count` reads 0 on the frame-wrap edge.
